// File: rtl/sram_sequencer.sv
// Sequencer that turns one accepted CPU request into a timed async SRAM cycle.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   req, rw       : request valid; rw 2'b10 read, 2'b01 write, others no-op
//   addr, wdata   : word address and write data, latched on accept
//   ready         : high only in IDLE
//   done          : one-cycle pulse on completion
//   rdata         : last read word, held until the next read completes
//   dataBus       : bidirectional SRAM data, driven only in write states
//   addrBus       : {BANK, latched addr}
//   memRead/memWrite/memEnable : active-low OE/WE/CE, all registered
module sram_sequencer #(
  parameter int unsigned RD_WAIT = 1,
  parameter int unsigned WR_WAIT = 1,
  parameter logic [1:0]  BANK    = 2'b00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [1:0]  rw,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        ready,
  output logic        done,
  output logic [15:0] rdata,
  inout  wire  [15:0] dataBus,
  output logic [17:0] addrBus,
  output logic        memRead,
  output logic        memWrite,
  output logic        memEnable
);

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;

  // Zero waits behave as one; anything above the counter range saturates.
  function automatic logic [CW-1:0] clamp_wait(input int unsigned w);
    if (w == 0) return CW'(1);
    if (w > 15) return CW'(15);
    return CW'(w);
  endfunction

  localparam logic [CW-1:0] RD_LOAD = clamp_wait(RD_WAIT) - CW'(1);
  localparam logic [CW-1:0] WR_LOAD = clamp_wait(WR_WAIT) - CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            accept;
  logic            capture;
  logic            drive_q;
  logic [DW-1:0]   dout_q;

  logic            ready_d, done_d, rd_n_d, wr_n_d, en_n_d, drive_d;

  // Next-state, counter and next-cycle pin values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req && (rw == 2'b10 || rw == 2'b01)) begin
          accept = 1'b1;
          if (rw == 2'b10) begin
            state_d = S_RD;
            cnt_d   = RD_LOAD;
          end else begin
            state_d = S_WR_SETUP;
          end
        end
      end
      S_RD: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_WR_SETUP: begin
        state_d = S_WR_PULSE;
        cnt_d   = WR_LOAD;
      end
      S_WR_PULSE: begin
        if (cnt_q == '0) state_d = S_WR_HOLD;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_WR_HOLD: state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // Pins are decoded from the next state so they change cleanly off the flops.
    ready_d = (state_d == S_IDLE);
    done_d  = (state_d == S_DONE);
    rd_n_d  = (state_d != S_RD);
    wr_n_d  = (state_d != S_WR_PULSE);
    drive_d = (state_d == S_WR_SETUP) || (state_d == S_WR_PULSE) ||
              (state_d == S_WR_HOLD);
    en_n_d  = !((state_d == S_RD) || drive_d);
  end

  // State, counter, latched request and registered pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ready     <= 1'b1;
      done      <= 1'b0;
      rdata     <= '0;
      addrBus   <= '0;
      memRead   <= 1'b1;
      memWrite  <= 1'b1;
      memEnable <= 1'b1;
      drive_q   <= 1'b0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ready     <= ready_d;
      done      <= done_d;
      memRead   <= rd_n_d;
      memWrite  <= wr_n_d;
      memEnable <= en_n_d;
      drive_q   <= drive_d;
      if (accept) begin
        addrBus <= {BANK, addr};
        dout_q  <= wdata;
      end
      if (capture) rdata <= dataBus;
    end
  end

  assign dataBus = drive_q ? dout_q : {DW{1'bz}};

endmodule

// File: tb/tb_sram_sequencer.sv
// Self-checking bench for sram_sequencer with a behavioural SRAM and reference memory.
module tb_sram_sequencer;

  localparam int unsigned RD_WAIT = 2;
  localparam int unsigned WR_WAIT = 1;
  localparam logic [1:0]  BANK    = 2'b00;
  localparam int unsigned RD_LAT  = RD_WAIT + 1;
  localparam int unsigned WR_LAT  = WR_WAIT + 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [1:0]  rw;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        ready;
  logic        done;
  logic [15:0] rdata;
  tri1  [15:0] databus;
  logic [17:0] addrBus;
  logic        memRead;
  logic        memWrite;
  logic        memEnable;

  int total = 0;
  int bad   = 0;

  logic [15:0] sram    [0:65535];
  logic [15:0] ref_mem [0:15];
  logic [15:0] exp_rdata;

  sram_sequencer #(.RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT), .BANK(BANK)) dut (
    .clk(clk), .rst(rst), .req(req), .rw(rw), .addr(addr), .wdata(wdata),
    .ready(ready), .done(done), .rdata(rdata), .dataBus(databus),
    .addrBus(addrBus), .memRead(memRead), .memWrite(memWrite),
    .memEnable(memEnable)
  );

  always #5 clk = ~clk;

  // Async SRAM chip: drives data while OE and CE are low, stores while WE and CE are low.
  assign databus = (!memRead && !memEnable) ? sram[addrBus[15:0]] : 16'hzzzz;

  always @(negedge clk) begin
    if (memWrite === 1'b0 && memEnable === 1'b0) sram[addrBus[15:0]] <= databus;
  end

  // OE and WE must never be low together.
  always @(negedge clk) begin
    total++;
    if (memRead === 1'b0 && memWrite === 1'b0) begin
      bad++;
      $display("FAIL strobe_overlap: memRead=%b memWrite=%b required not both 0", memRead, memWrite);
    end
  end

  function automatic logic [15:0] init_val(input int i);
    return 16'((i * 40503 + 17) & 16'h7FFF);
  endfunction

  task automatic start_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    req = 1'b1; rw = op; addr = a; wdata = d;
    @(posedge clk);
  endtask

  task automatic scramble();
    req = 1'b0; rw = 2'($urandom); addr = 16'($urandom); wdata = 16'($urandom);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    total++;
    if (ready !== 1'b1 || done !== 1'b0 || rdata !== 16'h0000 || addrBus !== 18'h0 ||
        memRead !== 1'b1 || memWrite !== 1'b1 || memEnable !== 1'b1 || databus !== 16'hFFFF) begin
      bad++;
      $display("FAIL reset: ready=%b done=%b rdata=%h addr=%h rd=%b wr=%b en=%b bus=%h required 1 0 0000 0 1 1 1 released",
               ready, done, rdata, addrBus, memRead, memWrite, memEnable, databus);
    end
    exp_rdata = 16'h0000;
  endtask

  task automatic test_read();
    start_op(2'b10, 16'h1234, 16'h0);
    for (int k = 1; k <= int'(RD_WAIT); k++) begin
      @(negedge clk);
      if (k == 1) scramble();
      total++;
      if (addrBus !== {BANK, 16'h1234} || memRead !== 1'b0 || memEnable !== 1'b0 ||
          memWrite !== 1'b1 || done !== 1'b0 || ready !== 1'b0) begin
        bad++;
        $display("FAIL read_cycle%0d: addr=%h rd=%b en=%b wr=%b done=%b ready=%b required 01234 0 0 1 0 0",
                 k, addrBus, memRead, memEnable, memWrite, done, ready);
      end
    end
    @(negedge clk);
    total++;
    if (done !== 1'b1 || rdata !== 16'hBEEF || memRead !== 1'b1 || memEnable !== 1'b1 || ready !== 1'b0) begin
      bad++;
      $display("FAIL read_done: done=%b rdata=%h rd=%b en=%b ready=%b required 1 beef 1 1 0",
               done, rdata, memRead, memEnable, ready);
    end
    exp_rdata = 16'hBEEF;
    @(negedge clk);
    total++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL read_ready: ready=%b done=%b required 1 0", ready, done);
    end
  endtask

  task automatic test_write();
    start_op(2'b01, 16'h0040, 16'h00A5);
    @(negedge clk);
    scramble();
    total++;
    if (memWrite !== 1'b1 || memEnable !== 1'b0 || memRead !== 1'b1 || databus !== 16'h00A5) begin
      bad++;
      $display("FAIL write_setup: wr=%b en=%b rd=%b bus=%h required 1 0 1 00a5", memWrite, memEnable, memRead, databus);
    end
    for (int k = 2; k <= int'(WR_WAIT) + 1; k++) begin
      @(negedge clk);
      total++;
      if (memWrite !== 1'b0 || memEnable !== 1'b0 || databus !== 16'h00A5 || addrBus !== {BANK, 16'h0040}) begin
        bad++;
        $display("FAIL write_pulse%0d: wr=%b en=%b bus=%h addr=%h required 0 0 00a5 00040", k, memWrite, memEnable, databus, addrBus);
      end
    end
    @(negedge clk);
    total++;
    if (memWrite !== 1'b1 || memEnable !== 1'b0 || databus !== 16'h00A5 || done !== 1'b0) begin
      bad++;
      $display("FAIL write_hold: wr=%b en=%b bus=%h done=%b required 1 0 00a5 0", memWrite, memEnable, databus, done);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b1 || databus !== 16'hFFFF || memEnable !== 1'b1 || sram[16'h0040] !== 16'h00A5 ||
        rdata !== exp_rdata) begin
      bad++;
      $display("FAIL write_done: done=%b bus=%h en=%b mem=%h rdata=%h required 1 released 1 00a5 %h",
               done, databus, memEnable, sram[16'h0040], rdata, exp_rdata);
    end
  endtask

  task automatic test_back_to_back();
    start_op(2'b01, 16'h0001, 16'h1111);
    @(negedge clk);
    rw = 2'b10; addr = 16'h0001; wdata = 16'h2222;
    for (int k = 1; k <= int'(WR_LAT); k++) begin
      if (k > 1) @(negedge clk);
      total++;
      if (ready !== 1'b0 || memRead !== 1'b1 || done !== (k == int'(WR_LAT))) begin
        bad++;
        $display("FAIL b2b_busy%0d: ready=%b rd=%b done=%b required 0 1 %0d", k, ready, memRead, done, k == int'(WR_LAT));
      end
    end
    ref_mem[1] = 16'h1111;
    @(negedge clk);
    total++;
    if (ready !== 1'b1 || sram[1] !== 16'h1111) begin
      bad++;
      $display("FAIL b2b_ready: ready=%b mem=%h required 1 1111", ready, sram[1]);
    end
    @(negedge clk);
    req = 1'b0;
    total++;
    if (memRead !== 1'b0 || ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_accept: rd=%b ready=%b required 0 0", memRead, ready);
    end
    repeat (RD_WAIT) @(negedge clk);
    exp_rdata = ref_mem[1];
    total++;
    if (done !== 1'b1 || rdata !== exp_rdata) begin
      bad++;
      $display("FAIL b2b_read: done=%b rdata=%h required 1 %h", done, rdata, exp_rdata);
    end
    repeat (2) @(negedge clk);
    total++;
    if (ready !== 1'b1 || memRead !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle: ready=%b rd=%b done=%b required 1 1 0", ready, memRead, done);
    end
  endtask

  task automatic test_noop();
    logic [1:0] ops [0:1];
    ops[0] = 2'b11; ops[1] = 2'b00;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      req = 1'b1; rw = ops[j]; addr = 16'($urandom); wdata = 16'($urandom);
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        total++;
        if (ready !== 1'b1 || done !== 1'b0 || memRead !== 1'b1 || memWrite !== 1'b1 || memEnable !== 1'b1) begin
          bad++;
          $display("FAIL noop_rw%b_%0d: ready=%b done=%b rd=%b wr=%b en=%b required 1 0 1 1 1",
                   ops[j], k, ready, done, memRead, memWrite, memEnable);
        end
      end
    end
    req = 1'b0;
  endtask

  task automatic test_abort();
    int lat;
    start_op(2'b01, 16'hFFF0, 16'h3C3C);
    @(negedge clk);
    scramble();
    @(negedge clk);
    total++;
    if (memWrite !== 1'b0) begin
      bad++;
      $display("FAIL abort_pulse: wr=%b required 0", memWrite);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_rdata = 16'h0000;
    total++;
    if (memWrite !== 1'b1 || memEnable !== 1'b1 || databus !== 16'hFFFF || done !== 1'b0 ||
        ready !== 1'b1 || rdata !== exp_rdata) begin
      bad++;
      $display("FAIL abort_reset: wr=%b en=%b bus=%h done=%b ready=%b rdata=%h required 1 1 released 0 1 0000",
               memWrite, memEnable, databus, done, ready, rdata);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0 || memEnable !== 1'b1) begin
        bad++;
        $display("FAIL abort_quiet%0d: done=%b en=%b required 0 1", k, done, memEnable);
      end
    end
    start_op(2'b10, 16'h0003, 16'h0);
    @(negedge clk);
    scramble();
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    exp_rdata = ref_mem[3];
    total++;
    if (lat != int'(RD_LAT) || rdata !== exp_rdata) begin
      bad++;
      $display("FAIL abort_recover: latency=%0d rdata=%h required %0d %h", lat, rdata, RD_LAT, exp_rdata);
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [15:0] a, d;
    int lat, w, exp_lat;
    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
      a  = 16'($urandom_range(0, 15));
      d  = 16'($urandom_range(0, 16'hFFFE));
      w  = 0;
      while (ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
      start_op(op, a, d);
      @(negedge clk);
      scramble();
      lat = 1;
      while (done !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
      if (op == 2'b10) begin
        exp_lat   = int'(RD_LAT);
        exp_rdata = ref_mem[a[3:0]];
      end else begin
        exp_lat = int'(WR_LAT);
        ref_mem[a[3:0]] = d;
      end
      total++;
      if (lat != exp_lat || rdata !== exp_rdata) begin
        bad++;
        $display("FAIL random%0d_rw%b_a%h: latency=%0d rdata=%h required %0d %h", i, op, a, lat, rdata, exp_lat, exp_rdata);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) sram[i] = init_val(i);
    for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
    sram[16'h1234] = 16'hBEEF;
    rst = 1'b1; req = 1'b0; rw = 2'b00; addr = 16'h0; wdata = 16'h0;
    exp_rdata = 16'h0000;
    test_reset();
    test_read();
    test_reset();
    test_write();
    test_back_to_back();
    test_noop();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at 200000, required finish");
    $fatal(1, "timeout");
  end

endmodule
